// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the elastic pipeline stage register.
//   stage_state_e : occupancy of the stage (EMPTY, FULL, SKID)
//   NOP_INSTR     : canonical bubble instruction, used by parents to build FLUSH_VALUE
//   CNT_W_DEFAULT : default performance-counter width
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  localparam logic [31:0]  NOP_INSTR     = 32'h0000_0013;
  localparam int unsigned  CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream producer / downstream consumer and
// pipe_stage_skid.
//   valid_i, data_i : upstream beat
//   ready_o         : stage can take a beat this cycle
//   stall_i         : downstream cannot consume this cycle
//   flush_i         : squash held and incoming beats
//   valid_o, data_o : output beat
// master = environment side, slave = stage side.
interface pipe_stage_skid_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             stall_i;
  logic             flush_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;

  modport master (
    output valid_i, data_i, stall_i, flush_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  valid_i, data_i, stall_i, flush_i,
    output ready_o, valid_o, data_o
  );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (priority over inc)
//   inc   : add one unless already all-ones
//   count : current value
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
//   clk, rst_i  : clock, synchronous active-high reset
//   start_i     : run enable; when low everything but start_o holds
//   start_o     : start_i delayed one cycle
//   bus         : handshake bundle (valid/data in, ready out, stall, flush,
//                 valid/data out)
//   stall_cnt_o : saturating count of cycles with start & stall & valid_o
//   flush_cnt_o : saturating count of cycles with start & flush
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH          = 64,
  parameter logic [WIDTH-1:0] FLUSH_VALUE    = '0,
  parameter bit               BUBBLE_SQUEEZE = 1'b1,
  parameter int unsigned      CNT_W          = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             start_o,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  stage_state_e     r_state;
  stage_state_e     w_next;
  logic             r_start;
  logic             r_ready;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_skid;

  logic             w_valid;
  logic             w_accept;
  logic             w_consume;
  logic             w_load_out;
  logic             w_out_from_skid;
  logic             w_load_skid;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_valid   = (r_state != EMPTY);
  assign w_accept  = bus.valid_i & r_ready;
  assign w_consume = w_valid & ~bus.stall_i;

  always_comb begin
    w_next          = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (start_i) begin
      if (bus.flush_i) begin
        w_next = EMPTY;
      end else begin
        unique case (r_state)
          EMPTY: begin
            // With BUBBLE_SQUEEZE=0 a beat offered while stalled is not
            // loaded even though ready_o is high; the parent must not
            // present beats into a stalled empty stage in that mode.
            if (w_accept && (!bus.stall_i || BUBBLE_SQUEEZE)) begin
              w_load_out = 1'b1;
              w_next     = FULL;
            end
          end
          FULL: begin
            if (w_consume && w_accept) begin
              w_load_out = 1'b1;
            end else if (w_consume) begin
              w_next = EMPTY;
            end else if (w_accept) begin
              w_load_skid = 1'b1;
              w_next      = SKID;
            end
          end
          SKID: begin
            if (w_consume) begin
              w_load_out      = 1'b1;
              w_out_from_skid = 1'b1;
              w_next          = FULL;
            end
          end
          default: w_next = EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_start <= 1'b0;
      r_state <= EMPTY;
      r_ready <= 1'b1;
      r_out   <= FLUSH_VALUE;
      r_skid  <= '0;
    end else begin
      r_start <= start_i;
      r_state <= w_next;
      // Registered ready: derived from the state we are about to enter.
      r_ready <= (w_next != SKID);
      if (w_load_out) begin
        r_out <= w_out_from_skid ? r_skid : bus.data_i;
      end
      if (w_load_skid) begin
        r_skid <= bus.data_i;
      end
    end
  end

  assign w_stall_inc = start_i & bus.stall_i & w_valid;
  assign w_flush_inc = start_i & bus.flush_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst_i),
    .inc   (w_stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst_i),
    .inc   (w_flush_inc),
    .count (flush_cnt_o)
  );

  assign start_o     = r_start;
  assign bus.ready_o = r_ready;
  assign bus.valid_o = w_valid;
  assign bus.data_o  = w_valid ? r_out : FLUSH_VALUE;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios followed by
// random traffic, all compared against a queue-based occupancy model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned      WIDTH = 64;
  localparam int unsigned      CNT_W = 4;
  localparam logic [WIDTH-1:0] FV    = {32'h0, NOP_INSTR};
  localparam bit               BS    = 1'b1;
  localparam int               MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             start_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  pipe_stage_skid_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_skid #(
    .WIDTH          (WIDTH),
    .FLUSH_VALUE    (FV),
    .BUBBLE_SQUEEZE (BS),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .start_o     (start_o),
    .bus         (bus.slave),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two beats; the head is
  // what is shown on the output.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ready = 1'b1;
  bit               m_start = 1'b0;
  int               m_stall_cnt = 0;
  int               m_flush_cnt = 0;

  task automatic step();
    bit was_valid;
    bit acc;
    bit cons;
    @(posedge clk);
    if (rst_i) begin
      m_q.delete();
      m_ready     = 1'b1;
      m_start     = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      m_start = start_i;
      if (start_i) begin
        was_valid = (m_q.size() != 0);
        if (bus.stall_i && was_valid && m_stall_cnt < MAXC) m_stall_cnt++;
        if (bus.flush_i) begin
          if (m_flush_cnt < MAXC) m_flush_cnt++;
          m_q.delete();
        end else begin
          acc  = bus.valid_i && m_ready;
          cons = was_valid && !bus.stall_i;
          if (cons) void'(m_q.pop_front());
          if (acc && (was_valid || !bus.stall_i || BS)) m_q.push_back(bus.data_i);
        end
        m_ready = (m_q.size() < 2);
      end
    end
    #1;
    check("valid_o", {63'd0, bus.valid_o}, {63'd0, m_q.size() != 0});
    check("data_o", bus.data_o, (m_q.size() != 0) ? m_q[0] : FV);
    check("ready_o", {63'd0, bus.ready_o}, {63'd0, m_ready});
    check("start_o", {63'd0, start_o}, {63'd0, m_start});
    check("stall_cnt", {60'd0, stall_cnt_o}, 64'(m_stall_cnt));
    check("flush_cnt", {60'd0, flush_cnt_o}, 64'(m_flush_cnt));
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit st,
                       input bit fl, input bit s);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.stall_i = st;
    bus.flush_i = fl;
    start_i     = s;
    step();
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = 64'hDEAD;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    step();
    step();
    check("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    check("rst_data", bus.data_o, FV);
    check("rst_ready", {63'd0, bus.ready_o}, 64'd1);
    check("rst_cnts", {56'd0, stall_cnt_o, flush_cnt_o}, 64'd0);
    rst_i = 1'b0;

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b0, 1'b0, 1'b1);
      check("stream_data", bus.data_o, 64'(i));
      check("stream_ready", {63'd0, bus.ready_o}, 64'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Stall into skid: A on output, B into skid, C held upstream
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'hB, 1'b1, 1'b0, 1'b1);
    check("skid_ready", {63'd0, bus.ready_o}, 64'd0);
    check("skid_head", bus.data_o, 64'hA);
    drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b1);
    check("stall_cnt3", {60'd0, stall_cnt_o}, 64'd3);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b1);
    check("release_b", bus.data_o, 64'hB);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b1);
    check("release_c", bus.data_o, 64'hC);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("drain_data", bus.data_o, FV);

    // Flush from SKID with a beat presented in the same cycle
    drive(1'b1, 64'h1A, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h1B, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 64'hD, 1'b0, 1'b1, 1'b1);
    check("flush_valid", {63'd0, bus.valid_o}, 64'd0);
    check("flush_data", bus.data_o, FV);
    check("flush_ready", {63'd0, bus.ready_o}, 64'd1);
    check("flush_cnt1", {60'd0, flush_cnt_o}, 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("flush_no_d", {63'd0, bus.valid_o}, 64'd0);

    // start_i gating with stall and flush asserted
    drive(1'b1, 64'h51, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h52, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h53, 1'b1, 1'b1, 1'b0);
      check("gate_start_o", {63'd0, start_o}, 64'd0);
      check("gate_data", bus.data_o, 64'h52);
      check("gate_flush_cnt", {60'd0, flush_cnt_o}, 64'd1);
    end
    drive(1'b1, 64'h53, 1'b0, 1'b0, 1'b1);
    check("resume_data", bus.data_o, 64'h53);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) < 7), {$urandom, $urandom},
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) != 0));
    end
    rst_i = 1'b0;

    // Counter saturation
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 64'h60, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("stall_sat", {60'd0, stall_cnt_o}, 64'hF);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("sat_cleared", {60'd0, stall_cnt_o}, 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed PC/instruction stage register. Carries a generic WIDTH-bit payload between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.
- Supports start gating, stall (downstream hold), flush with a configurable bubble value, and saturating stall/flush event counters.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with the payload concatenated by the parent.

Parameters:
- WIDTH, 64, payload width in bits (e.g. {PC, instruction}).
- FLUSH_VALUE, {WIDTH{1'b0}}, payload driven on data_o whenever valid_o=0.
- BUBBLE_SQUEEZE, 1, 1: an empty stage accepts input even while stall_i=1; 0: stall_i freezes all loading.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  global run enable; when 0, all state except start_o holds.
- start_o  output  1  start_i registered one cycle.
- valid_i  input  1  upstream payload valid.
- data_i  input  WIDTH  upstream payload.
- ready_o  output  1  stage can accept a beat this cycle (registered).
- stall_i  input  1  downstream cannot consume the output beat this cycle.
- flush_i  input  1  squash all held and incoming beats.
- valid_o  output  1  output payload valid.
- data_o  output  WIDTH  output payload.
- stall_cnt_o  output  CNT_W  cycles with start_i & stall_i & valid_o, saturating.
- flush_cnt_o  output  CNT_W  cycles with start_i & flush_i, saturating.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high: clk, rst_i.
  - rst_i has top priority.
  - On reset: start_o=0, valid_o=0, data_o=FLUSH_VALUE, ready_o=1, state=EMPTY, skid invalid, both counters=0.
- start_o <= start_i every non-reset cycle, regardless of other inputs.
- start_i=0: payload, state and counters hold; flush_i, valid_i and stall_i are ignored.
- Handshake:
  - Accept = valid_i & ready_o.
  - Consume = valid_o & !stall_i.
  - Latency is 1 cycle from accept to valid_o when the stage is empty.
- ready_o is registered and equals (next_state != SKID).
- State machine (start_i=1, flush_i=0):
  - EMPTY:
    - accept and (!stall_i or BUBBLE_SQUEEZE) -> load out register, go to FULL.
    - otherwise stay EMPTY.
  - FULL:
    - consume & accept -> out<=data_i, stay FULL. This is the full-throughput case.
    - consume & !accept -> go to EMPTY.
    - !consume & accept -> skid<=data_i, go to SKID.
    - !consume & !accept -> hold.
  - SKID (ready_o=0, so no accept is possible):
    - consume -> out<=skid, go to FULL.
    - otherwise hold.
- Flush:
  - flush_i=1 with start_i=1 overrides all loading and stall.
  - Next state is EMPTY; valid_o=0; data_o=FLUSH_VALUE; skid invalidated; ready_o=1.
  - A beat presented in the same cycle is dropped.
- data_o equals FLUSH_VALUE whenever valid_o=0, including after normal drain to EMPTY.
- Beats are never duplicated, reordered or lost, except by flush.
- Counters: increment by 1 on their condition and saturate at all-ones; flush_cnt increments even when the stage is empty.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, FULL, SKID} (2 bits).
  - Constants NOP_INSTR=32'h0000_0013 and the default CNT_W.
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clr), instantiated twice for the two counters.

Test Plan:
- Reset check: hold rst_i for 2 cycles with data_i=64'hDEAD -> valid_o=0, data_o=FLUSH_VALUE, ready_o=1, counters=0.
- Streaming: start_i=1, stall_i=0, stream beats 1..8 back-to-back -> data_o shows 1..8 one cycle later, valid_o continuous, ready_o always 1.
- Stall into skid:
  - Stream A, B, C; assert stall_i for 3 cycles while A is on the output.
  - Expect B captured into skid, ready_o=0 the cycle after, C held upstream.
  - On release: A, B, C emitted in order; stall_cnt_o=3.
- Flush:
  - With state=SKID holding A/B, assert flush_i alongside valid_i with D -> next cycle valid_o=0, data_o=FLUSH_VALUE, ready_o=1, flush_cnt_o=1.
  - D is never emitted.
- start_i gating: deassert start_i mid-stream with stall_i=1 and flush_i=1 -> outputs and counters frozen, start_o=0 one cycle later. Resume -> stream continues unchanged.
- Counter saturation, with CNT_W=4:
  - Hold stall_i with valid_o=1 for 20 cycles -> stall_cnt_o stops at 4'hF.
  - Pulse rst_i -> counter reads 0.
